// File: rtl/cmp_pkg.sv
// Shared constants for the serial magnitude comparator: FSM state codes,
// default operand width and the {gt,eq,lt} result encoding.
package cmp_pkg;

   localparam int DEF_WIDTH = 8;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic [2:0] RES_NONE = 3'b000;
   localparam logic [2:0] RES_GT   = 3'b100;
   localparam logic [2:0] RES_EQ   = 3'b010;
   localparam logic [2:0] RES_LT   = 3'b001;

   // The 1-bit stage must assert exactly one of its three flags.
   function automatic logic is_onehot3(input logic [2:0] v);
      return (v == RES_GT) || (v == RES_EQ) || (v == RES_LT);
   endfunction

endpackage

// File: rtl/cmp_shreg.sv
// WIDTH-bit parallel-load, left-shift register with an MSB tap; one
// instance per operand feeds the external 1-bit compare stage MSB first.
module cmp_shreg
   import cmp_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic             i_shift,
   input  logic [WIDTH-1:0] i_din,
   output logic             o_msb
);

   logic [WIDTH-1:0] r_data;

   // NOTE: non-blocking (<=) for every flop so all registers update together
   // at the edge; the data register is small, so it is reset like the rest.
   always_ff @(posedge clk) begin
      if (rst)
         r_data <= '0;
      else if (i_load)
         r_data <= i_din;
      else if (i_shift)
         r_data <= {r_data[WIDTH-2:0], 1'b0};
   end

   assign o_msb = r_data[WIDTH-1];

endmodule

// File: rtl/serial_cmp_ctrl.sv
// Bit-serial unsigned magnitude compare controller: streams operand bits MSB
// first to an external 1-bit stage and resolves the word result early.
module serial_cmp_ctrl
   import cmp_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_op_a,
   input  logic [WIDTH-1:0] i_op_b,
   output logic             o_busy,
   output logic             o_a_bit,
   output logic             o_b_bit,
   input  logic             i_bit_gt,
   input  logic             i_bit_eq,
   input  logic             i_bit_lt,
   output logic             o_done,
   output logic             o_a_gt_b,
   output logic             o_a_eq_b,
   output logic             o_a_lt_b,
   output logic             o_err
);

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_idx;
   logic             r_gt, r_eq, r_lt, r_err;

   logic       w_in_shift, w_load, w_shift, w_last, w_flags_ok;
   logic       w_msb_a, w_msb_b;
   logic [2:0] w_flags;

   assign w_in_shift = (r_state == ST_SHIFT);
   assign w_load     = (r_state == ST_IDLE) && i_start;
   assign w_flags    = {i_bit_gt, i_bit_eq, i_bit_lt};
   assign w_flags_ok = is_onehot3(w_flags);
   assign w_last     = (r_idx == CNT_W'(WIDTH - 1));
   // Advance only on a clean "equal" bit that is not the final one.
   assign w_shift    = w_in_shift && w_flags_ok && i_bit_eq && !w_last;

   cmp_shreg #(.WIDTH(WIDTH)) u_shreg_a (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load),
      .i_shift (w_shift),
      .i_din   (i_op_a),
      .o_msb   (w_msb_a)
   );

   cmp_shreg #(.WIDTH(WIDTH)) u_shreg_b (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load),
      .i_shift (w_shift),
      .i_din   (i_op_b),
      .o_msb   (w_msb_b)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_gt    <= 1'b0;
         r_eq    <= 1'b0;
         r_lt    <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_idx   <= '0;
                  r_gt    <= 1'b0;
                  r_eq    <= 1'b0;
                  r_lt    <= 1'b0;
                  r_err   <= 1'b0;
                  r_state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (!w_flags_ok) begin
                  r_err   <= 1'b1;
                  r_state <= ST_DONE;
               end else if (i_bit_gt) begin
                  r_gt    <= 1'b1;
                  r_state <= ST_DONE;
               end else if (i_bit_lt) begin
                  r_lt    <= 1'b1;
                  r_state <= ST_DONE;
               end else if (w_last) begin
                  r_eq    <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_idx   <= r_idx + 1'b1;
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_busy   = (r_state != ST_IDLE);
   assign o_done   = (r_state == ST_DONE);
   assign o_a_bit  = w_in_shift && w_msb_a;
   assign o_b_bit  = w_in_shift && w_msb_b;
   assign o_a_gt_b = r_gt;
   assign o_a_eq_b = r_eq;
   assign o_a_lt_b = r_lt;
   assign o_err    = r_err;

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Directed bench for serial_cmp_ctrl; the 1-bit compare stage is modelled
// here, with an override used to inject a non-one-hot flag fault.
module tb_serial_cmp_ctrl;
   import cmp_pkg::*;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst, start, fault_en;
   logic [WIDTH-1:0] op_a, op_b;
   logic             busy, a_bit, b_bit, bit_gt, bit_eq, bit_lt;
   logic             done, a_gt_b, a_eq_b, a_lt_b, err;
   logic [2:0]       res;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   assign bit_gt = fault_en | (a_bit & ~b_bit);
   assign bit_eq = a_bit ~^ b_bit;
   assign bit_lt = fault_en | (~a_bit & b_bit);
   assign res    = {a_gt_b, a_eq_b, a_lt_b};

   serial_cmp_ctrl #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .i_start  (start),
      .i_op_a   (op_a),
      .i_op_b   (op_b),
      .o_busy   (busy),
      .o_a_bit  (a_bit),
      .o_b_bit  (b_bit),
      .i_bit_gt (bit_gt),
      .i_bit_eq (bit_eq),
      .i_bit_lt (bit_lt),
      .o_done   (done),
      .o_a_gt_b (a_gt_b),
      .o_a_eq_b (a_eq_b),
      .o_a_lt_b (a_lt_b),
      .o_err    (err)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Start a compare, record the bit pairs presented, stop in the done cycle.
   task automatic run_compare(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              output int done_cyc,
                              output logic [WIDTH-1:0] seen_a, output logic [WIDTH-1:0] seen_b);
      op_a  = a;
      op_b  = b;
      start = 1'b1;
      tick;
      start    = 1'b0;
      done_cyc = 0;
      seen_a   = '0;
      seen_b   = '0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         if (done) begin
            done_cyc = cyc;
            break;
         end
         seen_a = {seen_a[WIDTH-2:0], a_bit};
         seen_b = {seen_b[WIDTH-2:0], b_bit};
         tick;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int               dc;
      int               done_hits;
      logic [WIDTH-1:0] sa, sb;

      rst = 1'b1; start = 1'b0; fault_en = 1'b0; op_a = '0; op_b = '0;
      tick;
      tick;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_res", res, RES_NONE);
      check("rst_err", err, 0);
      check("rst_bits", {a_bit, b_bit}, 2'b00);
      rst = 1'b0;
      tick;

      // Equal operands: eight bit pairs, done in cycle 9.
      run_compare(8'hA5, 8'hA5, dc, sa, sb);
      check("eq_done_cyc", dc, 9);
      check("eq_res", res, RES_EQ);
      check("eq_err", err, 0);
      check("eq_seen_a", sa, 8'hA5);
      check("eq_seen_b", sb, 8'hA5);
      tick;
      check("eq_done_pulse", done, 0);
      check("eq_idle", busy, 0);
      check("eq_bits_idle", {a_bit, b_bit}, 2'b00);
      tick;
      check("eq_held", res, RES_EQ);

      // MSB decides.
      run_compare(8'h80, 8'h7F, dc, sa, sb);
      check("msb_done_cyc", dc, 2);
      check("msb_res", res, RES_GT);
      check("msb_seen_a", sa, 8'h01);
      check("msb_seen_b", sb, 8'h00);
      tick;

      // LSB decides.
      run_compare(8'h12, 8'h13, dc, sa, sb);
      check("lsb_done_cyc", dc, 9);
      check("lsb_res", res, RES_LT);
      check("lsb_seen_a", sa, 8'h12);
      check("lsb_seen_b", sb, 8'h13);
      tick;

      // Start while busy, held through SHIFT and DONE cycles.
      op_a = 8'h0F; op_b = 8'hF0; start = 1'b1;
      tick;
      check("busy_c1_busy", busy, 1);
      op_a = 8'hFF;
      tick;
      check("busy_c2_done", done, 1);
      check("busy_c2_res", res, RES_LT);
      tick;
      start = 1'b0;
      check("busy_c3_idle", busy, 0);
      check("busy_c3_res", res, RES_LT);
      op_a = 8'hAA; op_b = 8'h55; start = 1'b1;
      tick;
      start = 1'b0;
      check("restart_busy", busy, 1);
      check("restart_clear", res, RES_NONE);
      tick;
      check("restart_done", done, 1);
      check("restart_res", res, RES_GT);
      tick;

      // Reset mid-operation.
      op_a = 8'h01; op_b = 8'h00; start = 1'b1;
      tick;
      start = 1'b0;
      done_hits = 0;
      for (int c = 1; c <= 3; c++) begin
         done_hits += int'(done);
         tick;
      end
      rst = 1'b1;
      done_hits += int'(done);
      tick;
      rst = 1'b0;
      check("rmid_busy", busy, 0);
      check("rmid_res", res, RES_NONE);
      check("rmid_err", err, 0);
      check("rmid_bits", {a_bit, b_bit}, 2'b00);
      for (int c = 0; c < 12; c++) begin
         done_hits += int'(done);
         tick;
      end
      check("rmid_no_done", done_hits, 0);
      check("rmid_still_idle", busy, 0);

      // Flag fault injected in cycle 3 of an equal compare.
      op_a = 8'h3C; op_b = 8'h3C; start = 1'b1;
      tick;
      start = 1'b0;
      tick;
      tick;
      check("fault_c3_done", done, 0);
      fault_en = 1'b1;
      tick;
      fault_en = 1'b0;
      check("fault_done", done, 1);
      check("fault_err", err, 1);
      check("fault_res", res, RES_NONE);
      tick;
      check("fault_err_held", err, 1);

      // A clean compare afterwards clears err; first difference at bit 6.
      run_compare(8'h01, 8'h02, dc, sa, sb);
      check("post_done_cyc", dc, 8);
      check("post_res", res, RES_LT);
      check("post_err", err, 0);
      tick;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/serial_cmp_ctrl.md
Name: serial_cmp_ctrl

Overview:
Controller for an N-bit magnitude comparison built from the existing single-bit compare stage.
- Upstream side: loads two N-bit operands and drives one bit pair per cycle, MSB first, into the 1-bit stage.
- Downstream side: samples the stage's gt/eq/lt flags and resolves the word-level result.
- Terminates early on the first differing bit, then reports the result with a done pulse.

Parameters:
WIDTH, 8, operand width in bits (legal range 2 to 32)
CNT_W, $clog2(WIDTH), width of the bit-index counter

Ports:
clk  in  1  system clock; all logic is rising-edge
rst  in  1  synchronous active-high reset
start  in  1  request to load op_a/op_b; honoured only in IDLE
op_a  in  WIDTH  operand A
op_b  in  WIDTH  operand B
busy  out  1  high in SHIFT and DONE
a_bit  out  1  current A bit to the 1-bit stage
b_bit  out  1  current B bit to the 1-bit stage
bit_gt  in  1  1-bit stage result a>b (combinational from a_bit/b_bit)
bit_eq  in  1  1-bit stage result a==b
bit_lt  in  1  1-bit stage result a<b
done  out  1  one-cycle pulse when the result is valid
a_gt_b  out  1  word result, held until next accepted start
a_eq_b  out  1  word result, held
a_lt_b  out  1  word result, held
err  out  1  flag-integrity fault, held until next accepted start

Behaviour:
- Reset (synchronous, active-high, clk and rst as named above):
  - Values: state=IDLE; sh_a, sh_b, idx=0; outputs busy, a_bit, b_bit, done, a_gt_b, a_eq_b, a_lt_b, err all 0.
  - Reset mid-operation aborts immediately. No done pulse is issued and any held result is cleared.
- State IDLE:
  - a_bit and b_bit are 0.
  - On start=1: sh_a<=op_a, sh_b<=op_b, idx<=0; clear a_gt_b, a_eq_b, a_lt_b and err; go to SHIFT.
- State SHIFT:
  - a_bit=sh_a[WIDTH-1] and b_bit=sh_b[WIDTH-1], driven combinationally from the registers.
  - The bit_* flags are sampled at the same clock edge. The round trip through the 1-bit stage must fit in one cycle.
  - Integrity check: if {bit_gt,bit_eq,bit_lt} is not one-hot, set err<=1, keep all results 0, and go to DONE.
  - If bit_gt=1: a_gt_b<=1, go to DONE.
  - If bit_lt=1: a_lt_b<=1, go to DONE.
  - If bit_eq=1 and idx==WIDTH-1: a_eq_b<=1, go to DONE.
  - Otherwise: shift both registers left by 1 (zero fill), idx<=idx+1, stay in SHIFT.
- State DONE:
  - done=1 for exactly this cycle, then go to IDLE.
  - Results stay stable from entry into DONE until the next accepted start.
- Latency: start is sampled at edge E0. Bit k (0 = MSB) is presented in cycle k+1. If the first differing bit is k, done is high in cycle k+2.
  - Equal operands: done in cycle WIDTH+1.
  - Best case (MSB differs): done in cycle 2.
- Start handling:
  - start is ignored while busy=1, including in the DONE cycle. Operands are not re-sampled.
  - start must be presented again in IDLE to be accepted.
- Results: exactly one of a_gt_b, a_eq_b, a_lt_b is set after a clean compare. None is set when err=1.
- Comparison is unsigned.
- idx never exceeds WIDTH-1. There is no wrap-around.

Decomposition:
- Shared package cmp_pkg holds:
  - state enum {IDLE, SHIFT, DONE} (2-bit encoding)
  - default WIDTH constant
  - result encoding constants used by benches
- One natural sub-module: cmp_shreg. It is a WIDTH-bit parallel-load, left-shift register with an MSB tap and is instantiated twice (A and B).
- The 1-bit compare stage is not instantiated inside this block. It is wired alongside it at the next level up (serial_cmp_top), so it can be swapped or checked independently.

Test Plan:
- Equal operands: op_a=8'hA5, op_b=8'hA5, start pulse -> 8 SHIFT cycles, done in cycle 9, a_eq_b=1, a_gt_b=0, a_lt_b=0, err=0.
- MSB decides: op_a=8'h80, op_b=8'h7F -> done in cycle 2, a_gt_b=1. The a_bit/b_bit pair seen is exactly one pair (1,0).
- LSB decides: op_a=8'h12, op_b=8'h13 -> done in cycle 9, a_lt_b=1. Bit pairs observed are MSB-first with the first 7 pairs equal.
- Start while busy: start op_a=8'h0F, op_b=8'hF0, then start=1 with op_a=8'hFF in cycle 1 -> ignored; a_lt_b=1 in cycle 2. A new start in IDLE after that is accepted and clears the results.
- Reset mid-operation: op_a=8'h01, op_b=8'h00, assert rst in cycle 4 -> next cycle state=IDLE, busy=0, all results 0, and no done pulse at any point.
- Flag fault: the bench forces bit_gt=1 and bit_lt=1 in cycle 3 of an equal-operand compare -> done in cycle 4, err=1, all three results 0.
